// File: rtl/pattern_det.sv
// Serial 10110 sequence detector with overlap. It emits a registered one-cycle pulse
// on the edge that accepts the completing 0.
module pattern_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic valid_i,
    output logic pattern
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_1    = 3'd1;
    localparam logic [2:0] S_10   = 3'd2;
    localparam logic [2:0] S_101  = 3'd3;
    localparam logic [2:0] S_1011 = 3'd4;

    logic [2:0] r_state;
    logic       r_pattern;
    logic [2:0] w_state_next;
    logic       w_match;

    // Each state is the longest suffix of the accepted bits that is also a prefix of 10110.
    always_comb begin
        w_state_next = r_state;
        w_match      = 1'b0;
        case (r_state)
            S_IDLE: if (valid_i) w_state_next = d_i ? S_1 : S_IDLE;
            S_1:    if (valid_i) w_state_next = d_i ? S_1 : S_10;
            S_10:   if (valid_i) w_state_next = d_i ? S_101 : S_IDLE;
            S_101:  if (valid_i) w_state_next = d_i ? S_1011 : S_10;
            S_1011: begin
                if (valid_i) begin
                    // The trailing "10" of a match is reused as the start of the next one.
                    w_state_next = d_i ? S_1 : S_10;
                    w_match      = ~d_i;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pattern <= w_match;
        end
    end

    assign pattern = r_pattern;

endmodule

// File: tb/tb_pattern_det.sv
// Self-checking bench for pattern_det. A queue-based model checks the last five
// accepted bits against 10110.
module tb_pattern_det;

    logic clk = 1'b0;
    logic rst;
    logic d_i;
    logic valid_i;
    logic pattern;

    int checks   = 0;
    int failures = 0;

    bit hist[$];
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    pattern_det dut (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern)
    );

    always #5 clk = ~clk;

    // Drives one cycle and advances the model. The expected pattern value after this
    // edge is returned in exp.
    task automatic apply(input bit r, input bit v, input bit d, output logic exp);
        bit hit;
        rst     = r;
        valid_i = v;
        d_i     = v ? d : 1'bx;
        @(posedge clk);
        #1;
        hit = 1'b0;
        if (r) begin
            hist.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() >= 5) begin
                hit = 1'b1;
                for (int k = 0; k < 5; k++)
                    if (hist[hist.size() - 5 + k] != pat[k]) hit = 1'b0;
            end
            if (hist.size() > 16) void'(hist.pop_front());
        end
        exp = hit;
    endtask

    task automatic test_reset();
        logic exp;
        int   pulses = 0;
        bit   seq[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b1, exp);
            checks++;
            if (pattern !== 1'b0) begin
                $display("FAIL reset_hold cycle=%0d got=%b want=0", i, pattern);
                failures++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, seq[i], exp);
            if (pattern === 1'b1) pulses++;
            checks++;
            if (pattern !== exp) begin
                $display("FAIL reset_release bit=%0d got=%b want=%b", i, pattern, exp);
                failures++;
            end
        end
        checks++;
        if (pulses != 0) begin
            $display("FAIL reset_no_match got=%0d want=0", pulses);
            failures++;
        end
        $display("test_reset done pulses=%0d", pulses);
    endtask

    task automatic test_single_match();
        logic exp;
        bit   seq[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b1, seq[i], exp);
            checks++;
            if (pattern !== ((i == 4) ? 1'b1 : 1'b0)) begin
                $display("FAIL single_match bit=%0d got=%b want=%b", i, pattern, (i == 4));
                failures++;
            end
        end
        $display("test_single_match done");
    endtask

    task automatic test_overlap();
        logic exp;
        int   pulses = 0;
        bit   seq[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, seq[i], exp);
            if (pattern === 1'b1) pulses++;
            checks++;
            if (pattern !== ((i == 4 || i == 7) ? 1'b1 : 1'b0)) begin
                $display("FAIL overlap bit=%0d got=%b want=%b", i, pattern, (i == 4 || i == 7));
                failures++;
            end
        end
        checks++;
        if (pulses != 2) begin
            $display("FAIL overlap_count got=%0d want=2", pulses);
            failures++;
        end
        $display("test_overlap done pulses=%0d", pulses);
    endtask

    task automatic test_valid_gaps();
        logic exp;
        int   pulses = 0;
        bit   v[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit   d[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit   miss[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, v[i], d[i], exp);
            if (pattern === 1'b1) pulses++;
            checks++;
            if (pattern !== ((i == 7) ? 1'b1 : 1'b0)) begin
                $display("FAIL valid_gap step=%0d got=%b want=%b", i, pattern, (i == 7));
                failures++;
            end
        end
        // Clear history with a zero, then apply the near misses 1010 and 10111.
        apply(1'b0, 1'b1, 1'b0, exp);
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, miss[i], exp);
            if (pattern === 1'b1) pulses++;
            checks++;
            if (pattern !== 1'b0 || exp !== 1'b0) begin
                $display("FAIL near_miss bit=%0d got=%b want=0", i, pattern);
                failures++;
            end
        end
        $display("test_valid_gaps done pulses=%0d", pulses);
    endtask

    task automatic test_mid_reset();
        logic exp;
        bit   pre[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit   post[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply(1'b0, 1'b1, 1'b0, exp);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, pre[i], exp);
        apply(1'b1, 1'b0, 1'b0, exp);
        apply(1'b0, 1'b1, 1'b0, exp);
        checks++;
        if (pattern !== 1'b0) begin
            $display("FAIL mid_reset_discard got=%b want=0", pattern);
            failures++;
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, post[i], exp);
            checks++;
            if (pattern !== ((i == 4) ? 1'b1 : 1'b0)) begin
                $display("FAIL mid_reset_rematch bit=%0d got=%b want=%b", i, pattern, (i == 4));
                failures++;
            end
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_random_soak(input int n, input int valid_pct);
        logic exp;
        logic prev      = 1'b0;
        int   dut_edges = 0;
        int   ref_count = 0;
        int   cyc_err   = 0;
        bit   v;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(99) < valid_pct);
            apply(1'b0, v, 1'($urandom_range(1)), exp);
            if (exp) ref_count++;
            if (pattern === 1'b1 && prev !== 1'b1) dut_edges++;
            prev = pattern;
            if (pattern !== exp) begin
                cyc_err++;
                if (cyc_err <= 5)
                    $display("FAIL soak_cycle i=%0d got=%b want=%b", i, pattern, exp);
            end
        end
        checks++;
        if (cyc_err != 0) begin
            $display("FAIL soak_cycles mismatched=%0d want=0", cyc_err);
            failures++;
        end
        checks++;
        if (dut_edges != ref_count) begin
            $display("FAIL soak_count got=%0d want=%0d", dut_edges, ref_count);
            failures++;
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(1)), exp);
            checks++;
            if (pattern !== 1'b0) begin
                $display("FAIL soak_idle cycle=%0d got=%b want=0", i, pattern);
                failures++;
            end
        end
        $display("test_random_soak n=%0d valid_pct=%0d edges=%0d ref=%0d", n, valid_pct, dut_edges, ref_count);
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        d_i     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_match();
        test_overlap();
        test_valid_gaps();
        test_mid_reset();
        test_random_soak(20000, 100);
        test_random_soak(20000, 70);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
